// File: rtl/scandoubler_pkg.sv
// -----------------------------------------------------------------------------
// scandoubler_pkg
//   Shared types and constants for the VGA scandoubler controller.
//   - lock_state_t : line-length lock FSM states
//   - CNT_W/ADDR_W : per-bank pixel counter width and full RAM address width
//   - BANK_BIT     : index of the bank-select bit inside a RAM address
//   - abs_diff     : unsigned |a - b| on counter-width values
// -----------------------------------------------------------------------------
package scandoubler_pkg;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned BANK_BIT = 10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        MEASURE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/scandoubler_if.sv
// -----------------------------------------------------------------------------
// scandoubler_if
//   Bundles the source timing inputs, mode requests, scanline RAM addressing
//   and regenerated VGA timing outputs of the scandoubler controller.
//   master : source video / system side (drives strobes and requests)
//   slave  : scandoubler_ctrl (drives RAM addresses and VGA timing)
// -----------------------------------------------------------------------------
interface scandoubler_if;
    import scandoubler_pkg::*;

    logic              ce_video;
    logic              hsync_n_in;
    logic              vsync_n_in;
    logic              scandouble_req;
    logic              scanlines_req;

    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              hsync_vga;
    logic              vsync_vga;
    logic              dim_line;
    logic              sd_active;
    logic              locked;
    logic [CNT_W-1:0]  line_len;

    modport master (
        output ce_video, hsync_n_in, vsync_n_in, scandouble_req, scanlines_req,
        input  wr_addr, wr_en, rd_addr, hsync_vga, vsync_vga, dim_line,
               sd_active, locked, line_len
    );

    modport slave (
        input  ce_video, hsync_n_in, vsync_n_in, scandouble_req, scanlines_req,
        output wr_addr, wr_en, rd_addr, hsync_vga, vsync_vga, dim_line,
               sd_active, locked, line_len
    );

endinterface

// File: rtl/scandoubler_ctrl_lock.sv
// -----------------------------------------------------------------------------
// sd_lock_fsm
//   Line-length lock tracker. Compares each completed source line length
//   (wr_cnt at hs_edge) with the previously measured one (line_len).
//   Ports:
//     clkvga, rst_n  : clock, synchronous active-low reset
//     hs_edge        : qualified source hsync edge (one clkvga cycle)
//     overflow       : write counter reached saturation
//     wr_cnt         : current write counter (length of the line just ended)
//     line_len       : previously measured line length
//     locked         : state == LOCKED
//     locked_nxt     : value locked takes after this clock edge
// -----------------------------------------------------------------------------
module sd_lock_fsm
    import scandoubler_pkg::*;
#(
    parameter int unsigned LEN_TOL = 2
) (
    input  logic             clkvga,
    input  logic             rst_n,
    input  logic             hs_edge,
    input  logic             overflow,
    input  logic [CNT_W-1:0] wr_cnt,
    input  logic [CNT_W-1:0] line_len,
    output logic             locked,
    output logic             locked_nxt
);

    localparam logic [CNT_W-1:0] TOL = CNT_W'(LEN_TOL);

    lock_state_t state;
    lock_state_t state_nxt;
    logic        within_tol;

    always_ff @(posedge clkvga) begin
        if (!rst_n) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        within_tol = (abs_diff(wr_cnt, line_len) <= TOL);
        state_nxt  = state;
        if (overflow) begin
            state_nxt = UNLOCKED;
        end else if (hs_edge) begin
            case (state)
                UNLOCKED: state_nxt = MEASURE;
                MEASURE:  state_nxt = within_tol ? LOCKED : MEASURE;
                LOCKED:   state_nxt = within_tol ? LOCKED : UNLOCKED;
                default:  state_nxt = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        locked     = (state == LOCKED);
        locked_nxt = (state_nxt == LOCKED);
    end

endmodule

// File: rtl/scandoubler_ctrl.sv
// -----------------------------------------------------------------------------
// scandoubler_ctrl
//   Scanline-buffer sequencer and VGA timing regenerator. Runs on clkvga and
//   treats ce_video as the source pixel strobe (every 2nd clkvga cycle).
//   Each source line is written into one RAM bank while the previous line is
//   read twice from the other bank at clkvga rate.
//   Parameters:
//     HSYNC_CYCLES : VGA hsync low width from the start of each read pass
//     VSYNC_CYCLES : VGA vsync low width
//     LEN_TOL      : line-length difference still considered the same line
//     MIN_LINE     : hsync edges ignored while wr_cnt is below this
//   Ports:
//     clkvga, rst_n : clock, synchronous active-low reset
//     sd (slave)    : source timing / requests in; RAM addresses, wr_en,
//                     hsync_vga, vsync_vga, dim_line, sd_active, locked,
//                     line_len out (all registered)
// -----------------------------------------------------------------------------
module scandoubler_ctrl
    import scandoubler_pkg::*;
#(
    parameter int unsigned HSYNC_CYCLES = 94,
    parameter int unsigned VSYNC_CYCLES = 2744,
    parameter int unsigned LEN_TOL      = 2,
    parameter int unsigned MIN_LINE     = 128
) (
    input  logic         clkvga,
    input  logic         rst_n,
    scandoubler_if.slave sd
);

    localparam int unsigned VCNT_W = $clog2(VSYNC_CYCLES + 1);

    // Source edge detection
    logic              hs_prev;
    logic              vs_prev;
    logic              hs_edge;
    logic              vs_fall;
    logic              overflow;

    // Write side
    logic [CNT_W-1:0]  wr_cnt;
    logic              wr_bank;
    logic [CNT_W-1:0]  line_len;
    logic [ADDR_W-1:0] wr_addr_cur;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_en_q;

    // Read side
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  rd_cnt_nxt;
    logic              rd_bank;
    logic              pass;
    logic              pass_nxt;
    logic [ADDR_W-1:0] rd_addr_cur;

    // Vsync and mode
    logic [VCNT_W-1:0] vcnt;
    logic [VCNT_W-1:0] vcnt_nxt;
    logic              sd_active;
    logic              sd_active_nxt;

    // Lock
    logic              locked;
    logic              locked_nxt;

    // Registered outputs
    logic              hsync_q;
    logic              hsync_d;
    logic              vsync_q;
    logic              vsync_d;
    logic              dim_q;
    logic              dim_d;

    // ---------------------------------------------------------------- edges
    always_comb begin
        hs_edge  = sd.ce_video & ~sd.hsync_n_in & hs_prev &
                   (32'(wr_cnt) >= MIN_LINE);
        vs_fall  = sd.ce_video & ~sd.vsync_n_in & vs_prev;
        // Single-cycle pulse on the increment that reaches saturation, so a
        // late hsync at 1023 can still start a fresh measurement.
        overflow = sd.ce_video & ~hs_edge & (wr_cnt == (CNT_MAX - CNT_W'(1)));
    end

    // ------------------------------------------------------------ addresses
    always_comb begin
        wr_addr_cur                = '0;
        wr_addr_cur[CNT_W-1:0]     = wr_cnt;
        wr_addr_cur[BANK_BIT]      = wr_bank;
        rd_addr_cur                = '0;
        rd_addr_cur[CNT_W-1:0]     = rd_cnt;
        rd_addr_cur[BANK_BIT]      = rd_bank;
    end

    // ------------------------------------------------------- read sequencing
    always_comb begin
        rd_cnt_nxt = rd_cnt;
        pass_nxt   = pass;
        if (hs_edge) begin
            rd_cnt_nxt = '0;
            pass_nxt   = 1'b0;
        end else if (line_len == '0) begin
            rd_cnt_nxt = '0;
        end else if (rd_cnt == (line_len - CNT_W'(1))) begin
            rd_cnt_nxt = '0;
            pass_nxt   = 1'b1;
        end else begin
            rd_cnt_nxt = rd_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------ vsync and mode
    always_comb begin
        vcnt_nxt = vcnt;
        if (vcnt != '0) begin
            vcnt_nxt = vcnt - VCNT_W'(1);
        end else if (vs_fall) begin
            vcnt_nxt = VCNT_W'(VSYNC_CYCLES);
        end

        // Mode is frozen while a vsync pulse runs so it is never cut short.
        sd_active_nxt = sd_active;
        if (vcnt == '0) begin
            if (!locked || vs_fall) begin
                sd_active_nxt = sd.scandouble_req;
            end
        end
    end

    // ----------------------------------------------------- output decoding
    // Decoded from next-state values so the registered outputs line up with
    // the registered counters (first hsync low 1 cycle after hs_edge).
    always_comb begin
        if (!sd_active_nxt) begin
            hsync_d = sd.hsync_n_in;
        end else if (!locked_nxt) begin
            hsync_d = 1'b1;
        end else begin
            hsync_d = !(32'(rd_cnt_nxt) < HSYNC_CYCLES);
        end
        vsync_d = sd_active_nxt ? (vcnt_nxt == '0) : 1'b1;
        dim_d   = pass_nxt & sd.scanlines_req & sd_active_nxt;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clkvga) begin
        if (!rst_n) begin
            hs_prev   <= 1'b1;
            vs_prev   <= 1'b1;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            line_len  <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= 1'b0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            pass      <= 1'b0;
            vcnt      <= '0;
            sd_active <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            dim_q     <= 1'b0;
        end else begin
            if (sd.ce_video) begin
                hs_prev   <= sd.hsync_n_in;
                vs_prev   <= sd.vsync_n_in;
                wr_addr_q <= wr_addr_cur;
                if (hs_edge) begin
                    line_len <= wr_cnt;
                    wr_bank  <= ~wr_bank;
                    wr_cnt   <= '0;
                end else if (wr_cnt != CNT_MAX) begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end
            wr_en_q <= sd.ce_video;

            if (hs_edge) begin
                rd_bank <= wr_bank;
            end
            rd_cnt    <= rd_cnt_nxt;
            pass      <= pass_nxt;
            vcnt      <= vcnt_nxt;
            sd_active <= sd_active_nxt;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            dim_q     <= dim_d;
        end
    end

    sd_lock_fsm #(
        .LEN_TOL (LEN_TOL)
    ) u_lock (
        .clkvga     (clkvga),
        .rst_n      (rst_n),
        .hs_edge    (hs_edge),
        .overflow   (overflow),
        .wr_cnt     (wr_cnt),
        .line_len   (line_len),
        .locked     (locked),
        .locked_nxt (locked_nxt)
    );

    assign sd.wr_addr   = wr_addr_q;
    assign sd.wr_en     = wr_en_q;
    assign sd.rd_addr   = rd_addr_cur;
    assign sd.hsync_vga = hsync_q;
    assign sd.vsync_vga = vsync_q;
    assign sd.dim_line  = dim_q;
    assign sd.sd_active = sd_active;
    assign sd.locked    = locked;
    assign sd.line_len  = line_len;

endmodule

// File: tb/tb_scandoubler_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scandoubler_ctrl
//   Directed self-checking bench for scandoubler_ctrl. Source pixels are
//   driven one ce_video cycle followed by one idle cycle; a source line
//   has its hsync low for the first 32 pixels.
// -----------------------------------------------------------------------------
module tb_scandoubler_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    // pulse statistics gathered on the falling clock edge
    int hs_run = 0, hs_pulses = 0, hs_last_w = 0;
    int vs_run = 0, vs_pulses = 0, vs_last_w = 0;

    scandoubler_if sd_bus ();

    scandoubler_ctrl #(
        .HSYNC_CYCLES (94),
        .VSYNC_CYCLES (2744),
        .LEN_TOL      (2),
        .MIN_LINE     (128)
    ) dut (
        .clkvga (clk),
        .rst_n  (rst_n),
        .sd     (sd_bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sd_bus.hsync_vga === 1'b0) hs_run++;
        else if (hs_run != 0) begin hs_last_w = hs_run; hs_pulses++; hs_run = 0; end
        if (sd_bus.vsync_vga === 1'b0) vs_run++;
        else if (vs_run != 0) begin vs_last_w = vs_run; vs_pulses++; vs_run = 0; end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    task automatic pix(input logic hs, input logic vs);
        @(posedge clk); #1;
        sd_bus.ce_video   = 1'b1;
        sd_bus.hsync_n_in = hs;
        sd_bus.vsync_n_in = vs;
        @(posedge clk); #1;
        sd_bus.ce_video   = 1'b0;
    endtask

    task automatic line_rest(input int len);
        for (int i = 1; i < len; i++) pix((i < 32) ? 1'b0 : 1'b1, 1'b1);
    endtask

    task automatic line(input int len);
        pix(1'b0, 1'b1);
        line_rest(len);
    endtask

    task automatic do_reset(input logic req);
        rst_n                 = 1'b0;
        sd_bus.ce_video       = 1'b0;
        sd_bus.hsync_n_in     = 1'b1;
        sd_bus.vsync_n_in     = 1'b1;
        sd_bus.scandouble_req = req;
        sd_bus.scanlines_req  = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // --------------------------------------------------------------- tests
    task automatic test_reset;
        rst_n                 = 1'b0;
        sd_bus.ce_video       = 1'b0;
        sd_bus.hsync_n_in     = 1'b1;
        sd_bus.vsync_n_in     = 1'b1;
        sd_bus.scandouble_req = 1'b0;
        sd_bus.scanlines_req  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (sd_bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", sd_bus.wr_en); end
        checks++; if (sd_bus.wr_addr !== 11'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", sd_bus.wr_addr); end
        checks++; if (sd_bus.rd_addr !== 11'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", sd_bus.rd_addr); end
        checks++; if (sd_bus.hsync_vga !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", sd_bus.hsync_vga); end
        checks++; if (sd_bus.vsync_vga !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", sd_bus.vsync_vga); end
        checks++; if (sd_bus.dim_line !== 1'b0) begin errors++; $display("FAIL reset_dim: got %b want 0", sd_bus.dim_line); end
        checks++; if (sd_bus.sd_active !== 1'b0) begin errors++; $display("FAIL reset_sd_active: got %b want 0", sd_bus.sd_active); end
        checks++; if (sd_bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", sd_bus.locked); end
        checks++; if (sd_bus.line_len !== 10'd0) begin errors++; $display("FAIL reset_line_len: got %0d want 0", sd_bus.line_len); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sd_bus.wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en: got %b want 0", sd_bus.wr_en); end
        checks++; if (sd_bus.rd_addr !== 11'd0) begin errors++; $display("FAIL idle_rd_addr: got %0d want 0", sd_bus.rd_addr); end
        // first ce_video: wr_en rises on the following cycle only
        sd_bus.ce_video = 1'b1;
        @(negedge clk);
        checks++; if (sd_bus.wr_en !== 1'b0) begin errors++; $display("FAIL first_ce_wr_en_early: got %b want 0", sd_bus.wr_en); end
        @(posedge clk); #1 sd_bus.ce_video = 1'b0;
        checks++; if (sd_bus.wr_en !== 1'b1) begin errors++; $display("FAIL first_ce_wr_en: got %b want 1", sd_bus.wr_en); end
        checks++; if (sd_bus.wr_addr !== 11'd0) begin errors++; $display("FAIL first_ce_wr_addr: got %0d want 0", sd_bus.wr_addr); end
        @(posedge clk); #1;
        checks++; if (sd_bus.wr_en !== 1'b0) begin errors++; $display("FAIL first_ce_wr_en_fall: got %b want 0", sd_bus.wr_en); end
    endtask

    task automatic test_lock;
        int hs_before;
        do_reset(1'b1);
        line(448);
        pix(1'b0, 1'b1);                       // hs_edge #1
        checks++; if (sd_bus.line_len !== 10'd448) begin errors++; $display("FAIL lock_line_len: got %0d want 448", sd_bus.line_len); end
        checks++; if (sd_bus.locked !== 1'b0) begin errors++; $display("FAIL lock_after_edge1: got %b want 0", sd_bus.locked); end
        checks++; if (sd_bus.hsync_vga !== 1'b1) begin errors++; $display("FAIL lock_hsync_unlocked: got %b want 1", sd_bus.hsync_vga); end
        line_rest(448);
        pix(1'b0, 1'b1);                       // hs_edge #2
        hs_before = hs_pulses;
        checks++; if (sd_bus.locked !== 1'b1) begin errors++; $display("FAIL lock_after_edge2: got %b want 1", sd_bus.locked); end
        checks++; if (sd_bus.hsync_vga !== 1'b0) begin errors++; $display("FAIL lock_hsync_start: got %b want 0", sd_bus.hsync_vga); end
        for (int i = 1; i <= 100; i++) pix((i < 32) ? 1'b0 : 1'b1, 1'b1);
        checks++; if (sd_bus.wr_addr !== 11'd99) begin errors++; $display("FAIL lock_wr_addr: got %0d want 99", sd_bus.wr_addr); end
        checks++; if (sd_bus.rd_addr[10] !== 1'b1) begin errors++; $display("FAIL lock_rd_bank: got %b want 1", sd_bus.rd_addr[10]); end
        for (int i = 101; i < 448; i++) pix(1'b1, 1'b1);
        pix(1'b0, 1'b1);                       // hs_edge #3
        checks++; if (hs_pulses - hs_before !== 2) begin errors++; $display("FAIL lock_hsync_pulses: got %0d want 2", hs_pulses - hs_before); end
        checks++; if (hs_last_w !== 94) begin errors++; $display("FAIL lock_hsync_width: got %0d want 94", hs_last_w); end
        checks++; if (sd_bus.locked !== 1'b1) begin errors++; $display("FAIL lock_hold: got %b want 1", sd_bus.locked); end
    endtask

    task automatic test_scanlines;
        do_reset(1'b1);
        sd_bus.scanlines_req = 1'b1;
        line(448);
        line(448);
        pix(1'b0, 1'b1);                       // locking edge, pass 0 begins
        checks++; if (sd_bus.dim_line !== 1'b0) begin errors++; $display("FAIL scan_pass0: got %b want 0", sd_bus.dim_line); end
        for (int i = 1; i < 300; i++) pix((i < 32) ? 1'b0 : 1'b1, 1'b1);
        checks++; if (sd_bus.dim_line !== 1'b1) begin errors++; $display("FAIL scan_pass1: got %b want 1", sd_bus.dim_line); end
        sd_bus.scanlines_req = 1'b0;
        pix(1'b1, 1'b1);
        checks++; if (sd_bus.dim_line !== 1'b0) begin errors++; $display("FAIL scan_off_now: got %b want 0", sd_bus.dim_line); end
        for (int i = 301; i < 448; i++) pix(1'b1, 1'b1);
        line(300);
        checks++; if (sd_bus.dim_line !== 1'b0) begin errors++; $display("FAIL scan_off_pass1: got %b want 0", sd_bus.dim_line); end
    endtask

    task automatic test_loss_of_lock;
        do_reset(1'b1);
        line(448);
        line(448);
        line(452);
        checks++; if (sd_bus.locked !== 1'b1) begin errors++; $display("FAIL loss_pre: got %b want 1", sd_bus.locked); end
        pix(1'b0, 1'b1);                       // edge after the 452-pixel line
        checks++; if (sd_bus.locked !== 1'b0) begin errors++; $display("FAIL loss_452: got %b want 0", sd_bus.locked); end
        line_rest(448);
        line(448);
        pix(1'b0, 1'b1);                       // relocked
        checks++; if (sd_bus.locked !== 1'b1) begin errors++; $display("FAIL loss_relock: got %b want 1", sd_bus.locked); end
        for (int i = 0; i < 1100; i++) pix(1'b1, 1'b1);
        checks++; if (sd_bus.wr_addr !== 11'd2047) begin errors++; $display("FAIL overflow_addr: got %0d want 2047", sd_bus.wr_addr); end
        checks++; if (sd_bus.locked !== 1'b0) begin errors++; $display("FAIL overflow_locked: got %b want 0", sd_bus.locked); end
    endtask

    task automatic test_mode_switch;
        do_reset(1'b1);
        line(448);
        line(448);
        pix(1'b0, 1'b1);
        for (int i = 1; i < 200; i++) pix((i < 32) ? 1'b0 : 1'b1, 1'b1);
        checks++; if (sd_bus.sd_active !== 1'b1) begin errors++; $display("FAIL mode_initial: got %b want 1", sd_bus.sd_active); end
        sd_bus.scandouble_req = 1'b0;
        for (int i = 200; i < 300; i++) pix(1'b1, 1'b1);
        checks++; if (sd_bus.sd_active !== 1'b1) begin errors++; $display("FAIL mode_held: got %b want 1", sd_bus.sd_active); end
        @(posedge clk); #1;
        sd_bus.ce_video   = 1'b1;
        sd_bus.vsync_n_in = 1'b0;
        @(negedge clk);
        checks++; if (sd_bus.sd_active !== 1'b1) begin errors++; $display("FAIL mode_before_edge: got %b want 1", sd_bus.sd_active); end
        @(posedge clk); #1 sd_bus.ce_video = 1'b0;
        checks++; if (sd_bus.sd_active !== 1'b0) begin errors++; $display("FAIL mode_after_edge: got %b want 0", sd_bus.sd_active); end
        checks++; if (sd_bus.locked !== 1'b1) begin errors++; $display("FAIL mode_locked: got %b want 1", sd_bus.locked); end
    endtask

    task automatic test_vsync_glitch;
        int vs_before;
        do_reset(1'b1);
        repeat (4) pix(1'b1, 1'b1);
        vs_before = vs_pulses;
        pix(1'b1, 1'b0);                       // vsync falling edge
        checks++; if (sd_bus.vsync_vga !== 1'b0) begin errors++; $display("FAIL vs_start: got %b want 0", sd_bus.vsync_vga); end
        repeat (4)  pix(1'b1, 1'b0);
        repeat (45) pix(1'b1, 1'b1);
        pix(1'b1, 1'b0);                       // second edge 100 cycles later
        repeat (4)  pix(1'b1, 1'b0);
        repeat (1500) pix(1'b1, 1'b1);
        checks++; if (vs_pulses - vs_before !== 1) begin errors++; $display("FAIL vs_count: got %0d want 1", vs_pulses - vs_before); end
        checks++; if (vs_last_w !== 2744) begin errors++; $display("FAIL vs_width: got %0d want 2744", vs_last_w); end
        checks++; if (sd_bus.vsync_vga !== 1'b1) begin errors++; $display("FAIL vs_idle: got %b want 1", sd_bus.vsync_vga); end

        // hsync glitch at wr_cnt=50 must not count as a line
        do_reset(1'b1);
        line(448);
        pix(1'b0, 1'b1);                       // edge: bank 1, wr_cnt 0
        for (int i = 1; i <= 50; i++) pix((i < 32) ? 1'b0 : 1'b1, 1'b1);
        pix(1'b0, 1'b1);                       // glitch, written at wr_cnt 50
        checks++; if (sd_bus.wr_addr !== 11'd1074) begin errors++; $display("FAIL glitch_addr: got %0d want 1074", sd_bus.wr_addr); end
        checks++; if (sd_bus.line_len !== 10'd448) begin errors++; $display("FAIL glitch_line_len: got %0d want 448", sd_bus.line_len); end
        pix(1'b1, 1'b1);
        checks++; if (sd_bus.wr_addr !== 11'd1075) begin errors++; $display("FAIL glitch_addr_next: got %0d want 1075", sd_bus.wr_addr); end
        for (int i = 53; i < 448; i++) pix(1'b1, 1'b1);
        pix(1'b0, 1'b1);
        checks++; if (sd_bus.locked !== 1'b1) begin errors++; $display("FAIL glitch_lock: got %b want 1", sd_bus.locked); end
    endtask

    initial begin
        sd_bus.ce_video       = 1'b0;
        sd_bus.hsync_n_in     = 1'b1;
        sd_bus.vsync_n_in     = 1'b1;
        sd_bus.scandouble_req = 1'b0;
        sd_bus.scanlines_req  = 1'b0;
        test_reset();
        test_lock();
        test_scanlines();
        test_loss_of_lock();
        test_mode_switch();
        test_vsync_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
